// File: rtl/fp_conv_arbiter_pkg.sv
// fp_conv_arbiter_pkg: shared field widths and FSM state encoding for the converter arbiter
package fp_conv_arbiter_pkg;
  localparam int FP_EXP_W = 4;
  localparam int FP_FRAC_W = 8;
  localparam int INT_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/fp_to_int.sv
// fp_to_int: 13-bit float (sign, exp, normalized frac) to sign-magnitude int; ports sign/exp/frac in, integ/uf/of out
module fp_to_int
  import fp_conv_arbiter_pkg::*;
(
  input  logic                 sign,
  input  logic [FP_EXP_W-1:0]  exp,
  input  logic [FP_FRAC_W-1:0] frac,
  output logic [INT_W-1:0]     integ,
  output logic                 uf,
  output logic                 of
);
  logic nz;
  logic [INT_W-2:0] mag;
  always_comb begin
    nz = frac[FP_FRAC_W-1];
    mag = (INT_W-1)'(({{(INT_W-1){1'b0}}, frac} << exp) >> FP_FRAC_W);
    integ = nz ? {sign, mag} : '0;
    uf = nz && exp == '0;
    of = nz && exp > FP_EXP_W'(7);
  end
endmodule

// File: rtl/fp_conv_arbiter.sv
// fp_conv_arbiter: round-robin sharing of one fp_to_int between two requesters; req/operands in, done/busy/owner/result/flag counters out
module fp_conv_arbiter
  import fp_conv_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req,
  input  logic [1:0]             req_sign,
  input  logic [2*FP_EXP_W-1:0]  req_exp,
  input  logic [2*FP_FRAC_W-1:0] req_frac,
  input  logic                   clr_cnt,
  output logic [1:0]             done,
  output logic                   busy,
  output logic                   owner,
  output logic [INT_W-1:0]       integ,
  output logic                   uf,
  output logic                   of,
  output logic [CNT_W-1:0]       uf_cnt,
  output logic [CNT_W-1:0]       of_cnt
);
  state_t state;
  logic ptr, win, op_sign, c_uf, c_of;
  logic [FP_EXP_W-1:0] op_exp;
  logic [FP_FRAC_W-1:0] op_frac;
  logic [INT_W-1:0] c_integ;
  always_comb begin
    win = (req == 2'b11) ? ~ptr : req[1];
    busy = state != IDLE;
  end
  fp_to_int u_conv (
    .sign (op_sign),
    .exp  (op_exp),
    .frac (op_frac),
    .integ(c_integ),
    .uf   (c_uf),
    .of   (c_of)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done <= '0;
      owner <= 1'b0;
      ptr <= 1'b1;
      integ <= '0;
      uf <= 1'b0;
      of <= 1'b0;
      op_sign <= 1'b0;
      op_exp <= '0;
      op_frac <= '0;
      uf_cnt <= '0;
      of_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          owner <= win;
          op_sign <= win ? req_sign[1] : req_sign[0];
          op_exp <= win ? req_exp[2*FP_EXP_W-1:FP_EXP_W] : req_exp[FP_EXP_W-1:0];
          op_frac <= win ? req_frac[2*FP_FRAC_W-1:FP_FRAC_W] : req_frac[FP_FRAC_W-1:0];
          state <= LOAD;
        end
        LOAD: begin
          integ <= c_integ;
          uf <= c_uf;
          of <= c_of;
          done <= owner ? 2'b10 : 2'b01;
          state <= RESP;
        end
        RESP: begin
          done <= '0;
          ptr <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      uf_cnt <= clr_cnt ? '0 : (state == RESP && uf && ~&uf_cnt) ? uf_cnt + 1'b1 : uf_cnt;
      of_cnt <= clr_cnt ? '0 : (state == RESP && of && ~&of_cnt) ? of_cnt + 1'b1 : of_cnt;
    end
  end
endmodule
